dft_bus_master: RTL and testbench

//  Bus initiator for the dft_block memory-mapped window (memwrite/adr/writedata/memdata).

---
 rtl/dft_bus_master_pkg.sv | 24 ++
 rtl/dft_bus_master_if.sv | 29 ++
 rtl/dft_bus_master.sv | 132 +++++++++++++
 tb/tb_dft_bus_master.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dft_bus_master_pkg.sv
// Shared definitions for the dft_block window master: FSM state encoding,
// default window geometry and a counter-width helper.
package dft_bus_master_pkg;

  localparam int          DEF_WIDTH  = 8;
  localparam int          DEF_AW     = 8;
  localparam int unsigned DEF_BASE   = 'hF8;
  localparam int          DEF_NWORDS = 8;
  localparam int          DEF_SETTLE = 2;

  typedef enum logic [2:0] {
    S_LOAD,
    S_SETTLE,
    S_RADDR,
    S_RCAP,
    S_OUT
  } state_e;

  // Counters never collapse to zero width, even for a single-value range.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dft_bus_master_if.sv
// Input stream, output stream and dft_block window bus bundled together.
interface dft_bus_master_if
  import dft_bus_master_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             memwrite;
  logic [AW-1:0]    adr;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] memdata;
  logic             frame_done;

  modport master (
    input  in_data, in_valid, out_ready, memdata,
    output in_ready, out_data, out_valid, memwrite, adr, writedata, frame_done
  );

  modport slave (
    output in_data, in_valid, out_ready, memdata,
    input  in_ready, out_data, out_valid, memwrite, adr, writedata, frame_done
  );
endinterface

// File: rtl/dft_bus_master.sv
// Writes one NWORDS frame from the input stream into the window at BASE, waits
// SETTLE idle bus cycles, then reads the window back onto the output stream.
module dft_bus_master
  import dft_bus_master_pkg::*;
#(
  parameter int          WIDTH  = DEF_WIDTH,
  parameter int          AW     = DEF_AW,
  parameter int unsigned BASE   = DEF_BASE,
  parameter int          NWORDS = DEF_NWORDS,
  parameter int          SETTLE = DEF_SETTLE
) (
  input logic              clk,
  input logic              rst_n,
  dft_bus_master_if.master m
);

  localparam int IW = cnt_w(NWORDS);
  localparam int CW = cnt_w(SETTLE);
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  if ((NWORDS < 1) || (SETTLE < 1) ||
      (BASE + NWORDS - 1 > (1 << AW) - 1)) begin : g_bad_params
    $error("dft_bus_master: window BASE..BASE+NWORDS-1 must fit in AW bits, SETTLE>=1");
  end

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             memwrite_q, memwrite_d;
  logic [AW-1:0]    adr_q, adr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] odata_q, odata_d;
  logic             ovalid_q, ovalid_d;
  logic             fdone_q, fdone_d;

  function automatic logic [AW-1:0] win_adr(input logic [IW-1:0] i);
    return AW'(BASE) + AW'(i);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LOAD;
      idx_q      <= '0;
      cnt_q      <= '0;
      memwrite_q <= 1'b0;
      adr_q      <= '0;
      wdata_q    <= '0;
      odata_q    <= '0;
      ovalid_q   <= 1'b0;
      fdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      memwrite_q <= memwrite_d;
      adr_q      <= adr_d;
      wdata_q    <= wdata_d;
      odata_q    <= odata_d;
      ovalid_q   <= ovalid_d;
      fdone_q    <= fdone_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    memwrite_d = 1'b0;
    adr_d      = adr_q;
    wdata_d    = wdata_q;
    odata_d    = odata_q;
    ovalid_d   = ovalid_q;
    fdone_d    = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        if (m.in_valid) begin
          memwrite_d = 1'b1;
          adr_d      = win_adr(idx_q);
          wdata_d    = m.in_data;
          if (idx_q == LAST) begin
            idx_d   = '0;
            cnt_d   = CW'(SETTLE - 1);
            state_d = S_SETTLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_SETTLE: begin
        // The final write occupies the first SETTLE cycle; idle counting starts after it.
        if (!memwrite_q) begin
          if (cnt_q == '0) begin
            adr_d   = win_adr(idx_q);
            state_d = S_RADDR;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      S_RADDR: state_d = S_RCAP;
      S_RCAP: begin
        odata_d  = m.memdata;
        ovalid_d = 1'b1;
        state_d  = S_OUT;
      end
      S_OUT: begin
        if (m.out_ready) begin
          ovalid_d = 1'b0;
          if (idx_q == LAST) begin
            idx_d   = '0;
            fdone_d = 1'b1;
            state_d = S_LOAD;
          end else begin
            idx_d   = idx_q + IW'(1);
            adr_d   = win_adr(idx_q + IW'(1));
            state_d = S_RADDR;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign m.in_ready   = (state_q == S_LOAD);
  assign m.memwrite   = memwrite_q;
  assign m.adr        = adr_q;
  assign m.writedata  = wdata_q;
  assign m.out_data   = odata_q;
  assign m.out_valid  = ovalid_q;
  assign m.frame_done = fdone_q;

endmodule

// File: tb/tb_dft_bus_master.sv
// Scoreboard bench: bench-side window memory returns mem[a]^a, so readback
// of word i is expected as sample_i ^ (BASE+i).
module tb_dft_bus_master;
  localparam int          W    = 8;
  localparam int          AW   = 8;
  localparam int unsigned BASE = 'hF8;
  localparam int          NW   = 8;
  localparam int          SET  = 2;

  typedef struct packed {
    logic         last;
    logic [W-1:0] d;
  } oexp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0, bad = 0, cyc = 0;

  dft_bus_master_if #(.WIDTH(W), .AW(AW)) m ();

  dft_bus_master #(.WIDTH(W), .AW(AW), .BASE(BASE), .NWORDS(NW), .SETTLE(SET)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m     (m)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (m.memwrite) mem[m.adr] <= m.writedata;
    m.memdata <= mem[m.adr] ^ m.adr;
  end

  logic [AW+W-1:0] wq[$];
  oexp_t           oq[$];
  logic [W-1:0]    fbuf[NW];
  int              k = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // out_ready: 0 = always high, 1 = random, 2 = five-cycle stall on word 3
  int rmode = 0, stall_n = 0;
  initial begin
    m.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        1: m.out_ready = ($urandom_range(0, 3) != 0);
        2: if (m.out_valid && m.adr == AW'(BASE + 3) && stall_n < 5) begin
             m.out_ready = 1'b0;
             stall_n++;
           end else m.out_ready = 1'b1;
        default: m.out_ready = 1'b1;
      endcase
    end
  end

  logic          fd_exp = 1'b0, held = 1'b0, reading = 1'b0;
  logic [W-1:0]  h_data;
  logic [AW-1:0] h_adr, prev_adr = '0;
  int            last_wr = 0, stall_obs = 0;
  initial begin
    oexp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0; fd_exp = 1'b0; reading = 1'b0;
      end else begin
        if (m.memwrite) begin
          if (reading) begin
            total++; bad++;
            $display("FAIL write_during_read: adr=%0h got memwrite=1 expected 0", m.adr);
          end
          if (wq.size() == 0) begin
            total++; bad++;
            $display("FAIL spurious_write: adr=%0h data=%0h expected none", m.adr, m.writedata);
          end else check("write", {16'h0, m.adr, m.writedata}, {16'h0, wq.pop_front()});
          last_wr = cyc;
        end else if (m.adr == AW'(BASE) && prev_adr != AW'(BASE)) begin
          check("settle_gap", cyc - last_wr, SET + 1);
          reading = 1'b1;
        end
        if (m.frame_done || fd_exp) begin
          check("frame_done", m.frame_done, fd_exp);
          if (m.frame_done) reading = 1'b0;
        end
        fd_exp = 1'b0;
        if (m.out_valid) begin
          if (held) begin
            check("stall_data", m.out_data, h_data);
            check("stall_adr", m.adr, h_adr);
          end
          if (m.out_ready) begin
            held = 1'b0;
            if (oq.size() == 0) begin
              total++; bad++;
              $display("FAIL spurious_out: got %0h expected none", m.out_data);
            end else begin
              e = oq.pop_front();
              check("out_data", m.out_data, e.d);
              fd_exp = e.last;
            end
          end else begin
            held = 1'b1; h_data = m.out_data; h_adr = m.adr; stall_obs++;
          end
        end
      end
      prev_adr = m.adr;
    end
  end

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input logic [W-1:0] d);
    int n = 0;
    m.in_valid = 1'b1;
    m.in_data  = d;
    while (!m.in_ready && n < 2000) begin @(negedge clk); n++; end
    if (!m.in_ready) begin
      total++; bad++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end else begin
      wq.push_back({AW'(BASE + k), d});
      fbuf[k] = d;
      k++;
      if (k == NW) begin
        for (int i = 0; i < NW; i++)
          oq.push_back(oexp_t'{last: (i == NW - 1), d: fbuf[i] ^ W'(BASE + i)});
        k = 0;
      end
    end
    @(negedge clk);
    m.in_valid = 1'b0;
  endtask

  task automatic frame(input int gapmax);
    for (int i = 0; i < NW; i++) begin
      repeat ($urandom_range(0, gapmax)) @(negedge clk);
      send(W'($urandom));
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((oq.size() != 0 || wq.size() != 0) && n < 3000) begin @(negedge clk); n++; end
    if (oq.size() != 0 || wq.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", oq.size() + wq.size());
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    m.in_valid = 1'b0;
    m.in_data  = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", m.in_ready, 1);
    check("rst_memwrite", m.memwrite, 0);
    check("rst_adr", m.adr, 0);
    check("rst_writedata", m.writedata, 0);
    check("rst_out_valid", m.out_valid, 0);
    check("rst_out_data", m.out_data, 0);
    check("rst_frame_done", m.frame_done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // contiguous frame A5..AC
    for (int i = 0; i < NW; i++) send(W'(8'hA5 + i));
    drain();

    // in_valid toggling 1,0,1,0
    for (int i = 0; i < NW; i++) begin send(W'($urandom)); @(negedge clk); end
    drain();

    // stall word 3 for five cycles
    stall_n = 0; stall_obs = 0; rmode = 2;
    frame(0);
    drain();
    check("stall_cycles", stall_obs, 5);
    rmode = 0;

    // reset while the fourth write is on the bus
    for (int i = 0; i < 4; i++) send(W'($urandom));
    #1 rst_n = 1'b0;
    #1;
    check("midrst_memwrite", m.memwrite, 0);
    check("midrst_out_valid", m.out_valid, 0);
    k = 0;
    wq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("midrst_in_ready", m.in_ready, 1);
    @(negedge clk);
    frame(0);
    drain();

    // back-to-back frames
    frame(0);
    frame(0);
    drain();

    // randomized gaps and backpressure
    rmode = 1;
    for (int f = 0; f < 6; f++) frame(3);
    drain();
    rmode = 0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
